// File: rtl/mul_pipe_ctrl.sv
// Valid/ready issue and result-collection wrapper around a fixed-latency multiplier.
// Optional synchronous flush input is enabled by defining MUL_PIPE_CTRL_FLUSH_EN.
module mul_pipe_ctrl #(
  parameter int SIGN_W     = 1,
  parameter int EXPO_W     = 8,
  parameter int MANT_W     = 23,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int DATA_W    = SIGN_W + EXPO_W + MANT_W,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MUL_PIPE_CTRL_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        in_rnd,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  output logic [1:0]        mul_rnd,
  input  logic [DATA_W-1:0] mul_res,
  input  logic [4:0]        mul_status,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [4:0]        out_status,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // in_ready/out_valid depend on registered state only; the producer holds
  // in_valid and operands stable until accepted.

  logic [LAT-1:0]    r_vld_sr;
  logic [CNT_W-1:0]  r_inflight;
  logic [CNT_W-1:0]  r_fifo_cnt;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0] r_mem_res [FIFO_DEPTH];
  logic [4:0]        r_mem_sts [FIFO_DEPTH];

  logic              w_flush;
  logic [CNT_W:0]    w_used;
  logic              w_fire_in;
  logic              w_fire_out;
  logic              w_wr_en;

`ifdef MUL_PIPE_CTRL_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Credits: every accepted op owns a FIFO slot from issue until it is popped.
  assign w_used     = {1'b0, r_fifo_cnt} + {1'b0, r_inflight};
  assign in_ready   = (w_used < DEPTH_C) && !w_flush;
  assign out_valid  = (r_fifo_cnt != '0) && !w_flush;
  assign w_fire_in  = in_valid && in_ready;
  assign w_fire_out = out_valid && out_ready;
  assign w_wr_en    = r_vld_sr[LAT-1] && !w_flush;

  assign mul_a      = in_a;
  assign mul_b      = in_b;
  assign mul_rnd    = in_rnd;
  assign out_res    = r_mem_res[r_rd_ptr];
  assign out_status = r_mem_sts[r_rd_ptr];
  assign busy       = (r_inflight != '0) || (r_fifo_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_sr   <= '0;
      r_inflight <= '0;
      r_fifo_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (w_flush) begin
      r_vld_sr   <= '0;
      r_inflight <= '0;
      r_fifo_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_vld_sr <= {r_vld_sr[LAT-2:0], w_fire_in};
      case ({w_fire_in, r_vld_sr[LAT-1]})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      case ({w_wr_en, w_fire_out})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      if (w_wr_en)    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_fire_out) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Result storage carries no reset; occupancy is tracked by r_fifo_cnt.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_res[r_wr_ptr] <= mul_res;
      r_mem_sts[r_wr_ptr] <= mul_status;
    end
  end

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Self-checking bench for mul_pipe_ctrl with a 2-cycle mock multiplier and a
// transaction-level model (queue of pending results with their ready cycle).
module tb_mul_pipe_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LATV  = 2;

  logic          clk;
  logic          rst;
  logic          flush_v;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [1:0]    in_rnd;
  logic [DW-1:0] mul_a;
  logic [DW-1:0] mul_b;
  logic [1:0]    mul_rnd;
  logic [DW-1:0] mul_res;
  logic [4:0]    mul_status;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_res;
  logic [4:0]    out_status;
  logic          busy;

  mul_pipe_ctrl dut (
    .clk        (clk),
    .rst        (rst),
`ifdef MUL_PIPE_CTRL_FLUSH_EN
    .flush      (flush_v),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rnd     (in_rnd),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_rnd    (mul_rnd),
    .mul_res    (mul_res),
    .mul_status (mul_status),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_status (out_status),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mock multiplier: known fp32 answers for the directed cases, a scrambling
  // function otherwise. Returns {res, status}.
  function automatic logic [36:0] mock_mul(logic [31:0] a, logic [31:0] b, logic [1:0] r);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000)      return {32'h4000_0000, 5'b00000};
    else if (a == 32'h7F80_0000 && b == 32'h0000_0000) return {32'h7FC0_0000, 5'b10000};
    else if (a == 32'h0000_0001 && b == 32'h0000_0001) return {32'h0000_0000, 5'b00011};
    else return {(a ^ {b[15:0], b[31:16]}) + {30'd0, r}, a[4:0] ^ b[4:0] ^ {3'b0, r}};
  endfunction

  logic [36:0] m_s1, m_s2;
  always @(posedge clk) begin
    m_s1 <= mock_mul(mul_a, mul_b, mul_rnd);
    m_s2 <= m_s1;
  end
  assign mul_res    = m_s2[36:5];
  assign mul_status = m_s2[4:0];

  logic [36:0] exp_q[$];
  int          rdy_q[$];
  int          cyc;
  int          n_pass;
  int          n_total;
  logic        last_acc;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Check outputs against the model, update the model, advance one cycle.
  task automatic cycle();
    logic e_rdy, e_ov, e_busy;
    e_rdy  = (exp_q.size() < DEPTH) && !flush_v;
    e_ov   = (exp_q.size() != 0) && !flush_v && (rdy_q[0] <= cyc);
    e_busy = (exp_q.size() != 0);
    check("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
    check("out_valid", {31'd0, out_valid}, {31'd0, e_ov});
    check("busy", {31'd0, busy}, {31'd0, e_busy});
    if (e_ov) begin
      check("out_res", out_res, exp_q[0][36:5]);
      check("out_status", {27'd0, out_status}, {27'd0, exp_q[0][4:0]});
    end
    last_acc = in_valid && e_rdy;
    if (flush_v) begin
      exp_q.delete();
      rdy_q.delete();
    end else begin
      if (e_ov && out_ready) begin
        void'(exp_q.pop_front());
        void'(rdy_q.pop_front());
      end
      if (last_acc) begin
        exp_q.push_back(mock_mul(in_a, in_b, in_rnd));
        rdy_q.push_back(cyc + LATV + 1);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(logic [31:0] a, logic [31:0] b, logic [1:0] r);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_rnd   = r;
    cycle();
  endtask

  // Random upstream: operands stay stable while a request waits for in_ready.
  task automatic drive_rand(int pct_valid);
    if (!(in_valid && !last_acc)) begin
      in_valid = ($urandom_range(0, 99) < pct_valid);
      in_a     = $urandom;
      in_b     = $urandom;
      in_rnd   = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    exp_q.delete();
    rdy_q.delete();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    cyc       = 0;
    last_acc  = 1'b0;
    rst       = 1'b1;
    flush_v   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_rnd    = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single op 1.0 * 2.0, visible three cycles after acceptance.
    out_ready = 1'b1;
    issue(32'h3F80_0000, 32'h4000_0000, 2'd0);
    idle(5);

    // Special values: inf*0 and denorm*denorm flags pass through.
    issue(32'h7F80_0000, 32'h0000_0000, 2'd0);
    issue(32'h0000_0001, 32'h0000_0001, 2'd1);
    idle(5);

    // Stream of 8 back-to-back ops with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      issue($urandom, $urandom, 2'($urandom_range(0, 3)));
      check("stream_in_ready", {31'd0, last_acc}, 32'd1);
    end
    idle(6);

    // Backpressure: only DEPTH accepts until the consumer drains.
    out_ready = 1'b0;
    in_valid  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_rand(100);
      cycle();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    idle(8);

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      drive_rand(70);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Reset in the middle of traffic, then no stale writes appear.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_rand(100);
      cycle();
    end
    do_reset();
    out_ready = 1'b1;
    idle(4);

`ifdef MUL_PIPE_CTRL_FLUSH_EN
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue($urandom, $urandom, 2'd2);
    in_valid = 1'b0;
    flush_v  = 1'b1;
    cycle();
    flush_v   = 1'b0;
    out_ready = 1'b1;
    idle(4);
`endif

    // Recovery after reset.
    for (int i = 0; i < 100; i++) begin
      drive_rand(80);
      out_ready = ($urandom_range(0, 1) != 0);
      cycle();
    end
    out_ready = 1'b1;
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
